// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: same-cycle hazard decode,
// saturating stall/flush counters, and a sticky data-memory watchdog.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_use,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {INIT, RUN, FREEZE, FAULT} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              active;
  logic              br_apply;
  logic              timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign active = (state == RUN) || (state == FREEZE);

  always_comb begin
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    br_apply     = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      INIT: begin
        if_id_we    = 1'b1;
        id_ex_we    = 1'b1;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_nxt   = RUN;
      end
      RUN, FREEZE: begin
        if (mem_busy) begin
          // Whole pipe holds; a pending branch stays in EX and is applied later.
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            state_nxt   = FAULT;
            timeout_hit = 1'b1;
          end else begin
            state_nxt = FREEZE;
          end
        end else begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
          ex_mem_we    = 1'b1;
          mem_wb_we    = 1'b1;
          id_ex_we     = 1'b1;
          if (br_taken) begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            br_apply    = 1'b1;
          end else if (ld_use) begin
            id_ex_flush = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_we = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      wait_cnt    <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (active && !pc_we) stall_cnt <= sat_inc(stall_cnt);
      if (br_apply)         flush_cnt <= sat_inc(flush_cnt);
      if (timeout_hit)      mem_timeout <= 1'b1;
    end
  end

endmodule
